// File: rtl/collision_monitor.sv
// collision_monitor
//   Watches the per-pixel overlap between the dino body and any obstacle
//   body.
//   Overlap pixels are counted within each frame. The count of a completed
//   frame is judged at the next frameStart.
//   A small game-state machine sequences the game:
//     IDLE -> GRACE (restart)
//     GRACE -> ARMED (after GRACE_FRAMES frames)
//     ARMED -> DEAD (hit)
//     DEAD -> GRACE (restart)
//
// Optional feature macro: COLLISION_COORD_EN
//   Defined:   the coordinates of the first overlap pixel of the fatal frame
//              are reported on collisionX/collisionY.
//   Undefined: collisionX/collisionY are tied to 0.
//
// Parameters
//   HIT_THRESHOLD  overlap pixels per frame that count as a hit (1..2047)
//   GRACE_FRAMES   frames after (re)start during which hits are ignored (1..15)
//
// Ports
//   pixelClk      in   1  pixel clock, one pixel per cycle
//   rst           in   1  synchronous active-high reset
//   frameStart    in   1  pulse on the first pixel of each frame
//   vgaX, vgaY    in  32  current pixel column / row
//   dinoGrey      in   1  pixel lies inside the dino body
//   obstacleGrey  in   1  pixel lies inside an obstacle body
//   restart       in   1  start / restart request pulse
//   isDead        out  1  game over, level
//   deadPulse     out  1  one-cycle pulse on entry to DEAD
//   gameState     out  2  IDLE=0 GRACE=1 ARMED=2 DEAD=3
//   overlapCount  out 11  overlap pixels so far in the current frame
//   collisionX/Y  out 32  first overlap pixel of the fatal frame
module collision_monitor #(
  parameter int HIT_THRESHOLD = 4,
  parameter int GRACE_FRAMES  = 2
) (
  input  logic        pixelClk,
  input  logic        rst,
  input  logic        frameStart,
  input  logic [31:0] vgaX,
  input  logic [31:0] vgaY,
  input  logic        dinoGrey,
  input  logic        obstacleGrey,
  input  logic        restart,
  output logic        isDead,
  output logic        deadPulse,
  output logic [1:0]  gameState,
  output logic [10:0] overlapCount,
  output logic [31:0] collisionX,
  output logic [31:0] collisionY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRACE = 2'd1,
    S_ARMED = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  localparam logic [10:0] HIT_LVL    = HIT_THRESHOLD[10:0];
  localparam logic [3:0]  GRACE_LOAD = GRACE_FRAMES[3:0];
  localparam logic [10:0] CNT_MAX    = 11'd2047;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_grace_cnt;
  logic [3:0]  w_grace_next;
  logic [10:0] r_overlap_cnt;
  logic [10:0] w_cnt_next;
  logic        r_is_dead;
  logic        r_dead_pulse;
  logic        w_enter_dead;
  logic        w_overlap;
  logic        w_hit;

  assign w_overlap = dinoGrey & obstacleGrey;
  // At frameStart the counter still holds the finished frame's total.
  assign w_hit     = (r_overlap_cnt >= HIT_LVL);

  // Per-frame overlap counter. A frameStart pixel belongs to the new frame.
  always_comb begin
    w_cnt_next = r_overlap_cnt;
    if (frameStart) begin
      w_cnt_next = w_overlap ? 11'd1 : 11'd0;
    end else if (w_overlap && (r_overlap_cnt != CNT_MAX)) begin
      w_cnt_next = r_overlap_cnt + 11'd1;
    end
  end

  // Next-state logic; restart outranks any frameStart evaluation.
  always_comb begin
    w_state_next = r_state;
    w_grace_next = r_grace_cnt;
    w_enter_dead = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (restart) begin
          w_state_next = S_GRACE;
          w_grace_next = GRACE_LOAD;
        end
      end
      S_GRACE: begin
        if (restart) begin
          w_grace_next = GRACE_LOAD;
        end else if (frameStart) begin
          w_grace_next = r_grace_cnt - 4'd1;
          if (r_grace_cnt == 4'd1) begin
            w_state_next = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (restart) begin
          w_state_next = S_GRACE;
          w_grace_next = GRACE_LOAD;
        end else if (frameStart && w_hit) begin
          w_state_next = S_DEAD;
          w_enter_dead = 1'b1;
        end
      end
      S_DEAD: begin
        if (restart) begin
          w_state_next = S_GRACE;
          w_grace_next = GRACE_LOAD;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pixelClk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grace_cnt   <= 4'd0;
      r_overlap_cnt <= 11'd0;
      r_is_dead     <= 1'b0;
      r_dead_pulse  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_grace_cnt   <= w_grace_next;
      r_overlap_cnt <= w_cnt_next;
      r_is_dead     <= (w_state_next == S_DEAD);
      r_dead_pulse  <= w_enter_dead;
    end
  end

  assign isDead       = r_is_dead;
  assign deadPulse    = r_dead_pulse;
  assign gameState    = r_state;
  assign overlapCount = r_overlap_cnt;

`ifdef COLLISION_COORD_EN
  logic [31:0] r_cand_x;
  logic [31:0] r_cand_y;
  logic [31:0] r_coll_x;
  logic [31:0] r_coll_y;
  logic        w_first_overlap;

  // First overlap of a frame: either on the frameStart pixel itself, or the
  // first one seen while the counter is still empty.
  assign w_first_overlap = w_overlap && (frameStart || (r_overlap_cnt == 11'd0));

  always_ff @(posedge pixelClk) begin
    if (rst) begin
      r_cand_x <= 32'd0;
      r_cand_y <= 32'd0;
      r_coll_x <= 32'd0;
      r_coll_y <= 32'd0;
    end else begin
      if (w_first_overlap) begin
        r_cand_x <= vgaX;
        r_cand_y <= vgaY;
      end
      // Candidates still describe the fatal frame here; a candidate update
      // in this same cycle belongs to the next frame.
      if (w_enter_dead) begin
        r_coll_x <= r_cand_x;
        r_coll_y <= r_cand_y;
      end
    end
  end

  assign collisionX = r_coll_x;
  assign collisionY = r_coll_y;
`else
  logic w_unused_coords;
  assign w_unused_coords = ^{vgaX, vgaY};
  assign collisionX      = 32'd0;
  assign collisionY      = 32'd0;
`endif

endmodule

// File: doc/collision_monitor.md
COLLISION_MONITOR -- requirements
Module: collision_monitor

Interface
REQ-001 SHALL have parameter HIT_THRESHOLD, default 4: overlapping pixels per frame needed to declare a hit (1..2047).
REQ-002 SHALL have parameter GRACE_FRAMES, default 2: frames after restart during which hits are ignored (1..15).
REQ-003 SHALL have port pixelClk, input, 1: single clock, one pixel per cycle.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port frameStart, input, 1: one-cycle pulse on the first pixel of each frame.
REQ-006 SHALL have port vgaX, input, 32: current pixel column.
REQ-007 SHALL have port vgaY, input, 32: current pixel row.
REQ-008 SHALL have port dinoGrey, input, 1: current pixel is inside the dino's grey body.
REQ-009 SHALL have port obstacleGrey, input, 1: current pixel is inside any obstacle's grey body.
REQ-010 SHALL have port restart, input, 1: one-cycle start or restart request.
REQ-011 SHALL have port isDead, output, 1: game over, level-held.
REQ-012 SHALL have port deadPulse, output, 1: one-cycle pulse on entry to DEAD.
REQ-013 SHALL have port gameState, output, 2: IDLE=0, GRACE=1, ARMED=2, DEAD=3.
REQ-014 SHALL have port overlapCount, output, 11: overlap pixels counted so far in the current frame.
REQ-015 SHALL have port collisionX, output, 32: column of the first overlap pixel of the frame that caused death.
REQ-016 SHALL have port collisionY, output, 32: row of the first overlap pixel of the frame that caused death.

Function
REQ-017 SHALL define an overlap pixel as a cycle with dinoGrey and obstacleGrey both high.
REQ-018 SHALL increment overlapCount by 1 on each overlap pixel and saturate it at 2047.
REQ-019 SHALL, on frameStart, load overlapCount with 1 if that cycle is an overlap pixel and with 0 otherwise.
REQ-020 SHALL, on frameStart, evaluate the previous frame's count against HIT_THRESHOLD, counting any overlap pixel in the frameStart cycle toward the new frame only.
REQ-021 SHALL, in IDLE, ignore overlaps for state purposes and move to GRACE when restart is high, loading the grace counter with GRACE_FRAMES.
REQ-022 SHALL, in GRACE, decrement the grace counter on each frameStart and move to ARMED on the frameStart that takes the counter to 0; no hit is evaluated in GRACE.
REQ-023 SHALL, in ARMED, move to DEAD on frameStart when the previous frame's count is greater than or equal to HIT_THRESHOLD.
REQ-024 SHALL set isDead and deadPulse in the cycle after the evaluating frameStart, with deadPulse lasting exactly 1 cycle.
REQ-025 SHALL, in DEAD, hold isDead at 1 and freeze collisionX and collisionY.
REQ-026 SHALL, on restart in DEAD, move to GRACE and clear isDead in the next cycle.
REQ-027 SHALL, on restart in GRACE or ARMED, reload the grace counter and move to GRACE.
REQ-028 SHALL give restart priority over a frameStart in the same cycle: the frame is not evaluated and the count still resets per REQ-019.
REQ-029 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, on rst high at a pixelClk edge, clear isDead, deadPulse, overlapCount, collisionX, collisionY and the grace counter, and set gameState to IDLE.
REQ-031 SHALL give rst priority over restart, frameStart and overlap, including in the middle of a frame.

Configuration
REQ-032 SHALL, with COLLISION_COORD_EN defined, latch vgaX and vgaY into per-frame candidate registers at the first overlap pixel of each frame, and copy the candidates to collisionX and collisionY on the transition to DEAD.
REQ-033 SHALL, without COLLISION_COORD_EN, tie collisionX and collisionY to 0 and omit the candidate registers.

Verification
REQ-034 SHALL cover: rst, restart, 3 frameStart pulses with no overlap -> gameState goes 0, 1, 1, 2; isDead stays 0.
REQ-035 SHALL cover: in ARMED, a frame with 4 overlap pixels (first at X=120, Y=200), then frameStart -> next cycle isDead=1, deadPulse=1 for one cycle, collisionX=120 and collisionY=200 (macro defined), or 0 and 0 (macro undefined).
REQ-036 SHALL cover: in ARMED, a frame with 3 overlap pixels, then frameStart -> state stays ARMED and overlapCount returns to 0.
REQ-037 SHALL cover: 10 overlap pixels in a frame during GRACE -> no death; state advances per REQ-022.
REQ-038 SHALL cover: in DEAD, restart asserted together with frameStart -> next cycle gameState=1 and isDead=0.
REQ-039 SHALL cover: 2100 overlap pixels in one frame -> overlapCount saturates at 2047; rst mid-frame -> all outputs 0 and gameState=0 on the next cycle.
